bcd_addsub_serial: RTL

BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_addsub_serial.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
// Holds the FSM state type, decimal constants and a digit validity helper.
package bcd_pkg;

    localparam int unsigned BCD_MAX    = 9;
    localparam int unsigned BCD_CORR   = 6;
    localparam int unsigned DIGITS_MAX = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary sum of two nibbles plus carry,
// corrected back into BCD when it exceeds nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] op_i,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] t;

    always_comb begin
        t     = {1'b0, a_i} + {1'b0, op_i} + {4'b0000, cin};
        digit = t[3:0];
        cout  = 1'b0;
        if (t > 5'(BCD_MAX)) begin
            digit = t[3:0] + 4'(BCD_CORR);
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor with valid/ready handshakes.
// One decimal digit per RUN cycle through a single shared digit adder.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [3:0]      op_dig;
    logic [3:0]      res_dig;
    logic            res_carry;
    logic            in_err;

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_bad(a[4*i +: 4]) || digit_bad(b[4*i +: 4])) begin
                in_err = 1'b1;
            end
        end
    end

    // Subtraction adds the nine's complement of B with carry-in preset to 1.
    always_comb begin
        a_dig  = a_q[4*int'(idx_q) +: 4];
        b_dig  = b_q[4*int'(idx_q) +: 4];
        op_dig = sub_q ? (4'(BCD_MAX) - b_dig) : b_dig;
    end

    bcd_digit_add u_digit_add (
        .a_i   (a_dig),
        .op_i  (op_dig),
        .cin   (carry_q),
        .digit (res_dig),
        .cout  (res_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = sub;
                    err_d   = in_err;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[4*int'(idx_q) +: 4] = res_dig;
                carry_d = res_carry;
                if (idx_q == IdxW'(DIGITS - 1)) begin
                    cout_d  = res_carry;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule
